fb_loader: RTL

FB_LOADER -- requirements
Module: fb_loader

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_rgb_packer.sv | 57 +++++
 rtl/fb_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared constants, state encoding and helpers for the framebuffer/palette loader.
// Defining FB_LOADER_CHECKSUM_EN adds the CHK state for a trailing checksum byte.
package fb_pkg;

  localparam logic [7:0] CMD_PAL   = 8'h50;
  localparam logic [7:0] CMD_PIX   = 8'h46;
  localparam int         PAL_BYTES = 768;
  localparam int         RGB_W     = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PAL  = 3'd1,
    ST_PIX  = 3'd2,
`ifdef FB_LOADER_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_DONE = 3'd4
  } fb_state_e;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_PAL) || (b == CMD_PIX);
  endfunction

endpackage

// File: rtl/fb_rgb_packer.sv
// Collects R, G, B bytes of one palette entry and flags the byte that completes it.
// rgb_o is valid in the same cycle as complete_o (blue byte is passed through).
module fb_rgb_packer
  import fb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [7:0]       data_i,
  output logic [RGB_W-1:0] rgb_o,
  output logic             complete_o
);

  logic [1:0] phase_q, phase_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;

  always_comb begin
    phase_d = phase_q;
    r_d     = r_q;
    g_d     = g_q;
    if (clr_i) begin
      phase_d = 2'd0;
    end else if (valid_i) begin
      case (phase_q)
        2'd0: begin
          r_d     = data_i;
          phase_d = 2'd1;
        end
        2'd1: begin
          g_d     = data_i;
          phase_d = 2'd2;
        end
        default: phase_d = 2'd0;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= 2'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
    end else begin
      phase_q <= phase_d;
      r_q     <= r_d;
      g_q     <= g_d;
    end
  end

  assign complete_o = valid_i && !clr_i && (phase_q == 2'd2);
  assign rgb_o      = {r_q, g_q, data_i};

endmodule

// File: rtl/fb_loader.sv
// Byte-stream loader for a palette RAM and an indexed framebuffer RAM.
// Optional trailing checksum byte when FB_LOADER_CHECKSUM_EN is defined.
module fb_loader
  import fb_pkg::*;
#(
  parameter int H_RES  = 800,
  parameter int V_RES  = 600,
  parameter int ADDR_W = 19
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              abort,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_d,
  output logic              pal_we,
  output logic [7:0]        pal_addr,
  output logic [RGB_W-1:0]  pal_d,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                NPIX     = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);
  localparam logic [9:0]        PAL_LAST = 10'(PAL_BYTES - 1);

  fb_state_e state_q, state_d;

  logic [9:0]        pal_cnt_q, pal_cnt_d;
  logic [7:0]        entry_q, entry_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              err_q, err_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_d_q, fb_d_d;
  logic              pal_we_q, pal_we_d;
  logic [7:0]        pal_addr_q, pal_addr_d;
  logic [RGB_W-1:0]  pal_d_q, pal_d_d;
`ifdef FB_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic             accept_s;
  logic             last_byte_s;
  logic             pack_done_s;
  logic [RGB_W-1:0] pack_rgb_s;

  assign s_ready     = !reset && !abort && (state_q != ST_DONE);
  assign accept_s    = s_valid && s_ready;
  assign last_byte_s = accept_s &&
                       (((state_q == ST_PAL) && (pal_cnt_q == PAL_LAST)) ||
                        ((state_q == ST_PIX) && (pix_cnt_q == PIX_LAST)));

  fb_rgb_packer u_packer (
    .clk_i      (sys_clk),
    .rst_i      (reset),
    .clr_i      (state_q == ST_IDLE),
    .valid_i    (accept_s && (state_q == ST_PAL)),
    .data_i     (s_data),
    .rgb_o      (pack_rgb_s),
    .complete_o (pack_done_s)
  );

  // State and datapath registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pal_cnt_q  <= 10'd0;
      entry_q    <= 8'd0;
      pix_cnt_q  <= '0;
      err_q      <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_d_q     <= 8'd0;
      pal_we_q   <= 1'b0;
      pal_addr_q <= 8'd0;
      pal_d_q    <= '0;
`ifdef FB_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      pal_cnt_q  <= pal_cnt_d;
      entry_q    <= entry_d;
      pix_cnt_q  <= pix_cnt_d;
      err_q      <= err_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_d_q     <= fb_d_d;
      pal_we_q   <= pal_we_d;
      pal_addr_q <= pal_addr_d;
      pal_d_q    <= pal_d_d;
`ifdef FB_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (s_data == CMD_PAL)) begin
          state_d = ST_PAL;
        end else if (accept_s && (s_data == CMD_PIX)) begin
          state_d = ST_PIX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAL, ST_PIX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_byte_s) begin
`ifdef FB_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = state_q;
        end
      end
`ifdef FB_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, error flag and write-port next values
  always_comb begin
    pal_cnt_d  = pal_cnt_q;
    entry_d    = entry_q;
    pix_cnt_d  = pix_cnt_q;
    err_d      = err_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_d_d     = fb_d_q;
    pal_we_d   = 1'b0;
    pal_addr_d = pal_addr_q;
    pal_d_d    = pal_d_q;
`ifdef FB_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_load_cmd(s_data)) begin
          err_d     = 1'b0;
          pal_cnt_d = 10'd0;
          entry_d   = 8'd0;
          pix_cnt_d = '0;
`ifdef FB_LOADER_CHECKSUM_EN
          sum_d     = 8'd0;
`endif
        end else if (accept_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_PAL: begin
        if (abort) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          pal_cnt_d = pal_cnt_q + 10'd1;
`ifdef FB_LOADER_CHECKSUM_EN
          sum_d     = sum_q + s_data;
`endif
          if (pack_done_s) begin
            pal_we_d   = 1'b1;
            pal_addr_d = entry_q;
            pal_d_d    = pack_rgb_s;
            entry_d    = entry_q + 8'd1;
          end else begin
            entry_d = entry_q;
          end
        end else begin
          err_d = err_q;
        end
      end
      ST_PIX: begin
        if (abort) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          fb_we_d   = 1'b1;
          fb_addr_d = pix_cnt_q;
          fb_d_d    = s_data;
`ifdef FB_LOADER_CHECKSUM_EN
          sum_d     = sum_q + s_data;
`endif
          // Hold at the last pixel so the address can never wrap.
          if (pix_cnt_q != PIX_LAST) begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          end else begin
            pix_cnt_d = pix_cnt_q;
          end
        end else begin
          err_d = err_q;
        end
      end
`ifdef FB_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (abort) begin
          err_d = 1'b1;
        end else if (accept_s && (s_data != sum_q)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
`endif
      ST_DONE: err_d = err_q;
      default: err_d = err_q;
    endcase
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_d     = fb_d_q;
  assign pal_we   = pal_we_q;
  assign pal_addr = pal_addr_q;
  assign pal_d    = pal_d_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule
